// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if
//  Groups the register-file write/read bus into one bundle.
//  Parameters:
//   DATA_W  register width in bits
//   ADDR_W  register address width
//   NUM_RD  number of read ports
//  Signals (names seen from the register file):
//   rd0_we_i, rd0_i, rd0_value_i   write port 0 (ALU/CSR writeback)
//   rd1_we_i, rd1_i, rd1_value_i   write port 1 (load/mul writeback)
//   ra_i                           packed read addresses, port k = ra_i[k*ADDR_W +: ADDR_W]
//   rv_o                           packed read data,      port k = rv_o[k*DATA_W +: DATA_W]
//   busy_o                         high while the post-reset clear sweep runs
//  Modports:
//   slave   the register file
//   master  decode/writeback side driving the bus
interface regfile_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     rd0_we_i;
  logic [ADDR_W-1:0]        rd0_i;
  logic [DATA_W-1:0]        rd0_value_i;
  logic                     rd1_we_i;
  logic [ADDR_W-1:0]        rd1_i;
  logic [DATA_W-1:0]        rd1_value_i;
  logic [NUM_RD*ADDR_W-1:0] ra_i;
  logic [NUM_RD*DATA_W-1:0] rv_o;
  logic                     busy_o;

  modport slave (
    input  rd0_we_i, rd0_i, rd0_value_i,
    input  rd1_we_i, rd1_i, rd1_value_i,
    input  ra_i,
    output rv_o, busy_o
  );

  modport master (
    output rd0_we_i, rd0_i, rd0_value_i,
    output rd1_we_i, rd1_i, rd1_value_i,
    output ra_i,
    input  rv_o, busy_o
  );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport
//  Parametrised integer register file for the RV32IM core family.
//  DEPTH x DATA_W flops, two write ports, NUM_RD combinational read ports,
//  optional hardwired-zero r0, and a post-reset sweep that zeroes every entry.
//  Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read of an entry written in the same READY cycle returns the
//               incoming write data (rd1 before rd0, dropped r0 writes never forwarded)
//   undefined - reads return the stored (pre-edge) value
//  Parameters:
//   DATA_W   register width
//   DEPTH    number of registers (power of 2, 4..64)
//   ADDR_W   address width, equal to $clog2(DEPTH)
//   NUM_RD   number of read ports (1..4)
//   R0_ZERO  1: address 0 reads 0 and writes to it are dropped
//  Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; restarts the clear sweep
//   rf       regfile_multiport_if.slave bus (write ports, read ports, busy_o)
module regfile_multiport #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_multiport_if.slave   rf
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                   state_r;
  state_t                   state_s;
  logic [ADDR_W-1:0]        clr_r;
  logic [ADDR_W-1:0]        clr_s;
  logic                     busy_r;
  logic                     wr0_ok_s;
  logic                     wr1_ok_s;
  logic [NUM_RD*DATA_W-1:0] rv_s;
  logic [DATA_W-1:0]        mem_r [DEPTH];

  // A write to r0 is dropped when r0 is hardwired to zero.
  assign wr0_ok_s = rf.rd0_we_i && !(R0_ZERO && (rf.rd0_i == ZERO_ADDR));
  assign wr1_ok_s = rf.rd1_we_i && !(R0_ZERO && (rf.rd1_i == ZERO_ADDR));

  // State register, sweep counter and busy flag; rst_i restarts the sweep from entry 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_CLEAR;
      clr_r   <= ZERO_ADDR;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      clr_r   <= clr_s;
      busy_r  <= (state_s == ST_CLEAR);
    end
  end

  // Next-state logic: CLEAR walks clr_r up to DEPTH-1, then READY holds until reset.
  always_comb begin
    state_s = state_r;
    clr_s   = clr_r;
    case (state_r)
      ST_CLEAR: begin
        clr_s = clr_r + ONE_ADDR;
        if (clr_r == LAST_ADDR) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_s = ST_READY;
      end
      default: begin
        state_s = ST_CLEAR;
        clr_s   = ZERO_ADDR;
      end
    endcase
  end

  // Storage update: sweep zeroing in CLEAR, port writes in READY; rd1 is assigned
  // after rd0 so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // contents are left alone; the sweep that follows zeroes them
    end else if (state_r == ST_CLEAR) begin
      mem_r[clr_r] <= {DATA_W{1'b0}};
    end else begin
      if (wr0_ok_s) begin
        mem_r[rf.rd0_i] <= rf.rd0_value_i;
      end
      if (wr1_ok_s) begin
        mem_r[rf.rd1_i] <= rf.rd1_value_i;
      end
    end
  end

  // Read mux: all ports read 0 during CLEAR, r0 reads 0 when hardwired,
  // otherwise the stored value or (with bypass) the in-flight write data.
  always_comb begin : read_mux
    logic [ADDR_W-1:0] ra_v;
    rv_s = {(NUM_RD*DATA_W){1'b0}};
    ra_v = ZERO_ADDR;
    for (int k = 0; k < NUM_RD; k++) begin
      ra_v = rf.ra_i[k*ADDR_W +: ADDR_W];
      if (state_r != ST_READY) begin
        rv_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (R0_ZERO && (ra_v == ZERO_ADDR)) begin
        rv_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else begin
`ifdef REGFILE_BYPASS_EN
        // r0 with R0_ZERO never reaches here, so dropped writes are not forwarded.
        if (!rst_i && rf.rd1_we_i && (rf.rd1_i == ra_v)) begin
          rv_s[k*DATA_W +: DATA_W] = rf.rd1_value_i;
        end else if (!rst_i && rf.rd0_we_i && (rf.rd0_i == ra_v)) begin
          rv_s[k*DATA_W +: DATA_W] = rf.rd0_value_i;
        end else begin
          rv_s[k*DATA_W +: DATA_W] = mem_r[ra_v];
        end
`else
        rv_s[k*DATA_W +: DATA_W] = mem_r[ra_v];
`endif
      end
    end
  end

  assign rf.rv_o   = rv_s;
  assign rf.busy_o = busy_r;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport
//  Self-checking bench for regfile_multiport. Three instances share clock and reset:
//   u_main  DEPTH=32, R0_ZERO=1
//   u_d16   DEPTH=16, R0_ZERO=1
//   u_nz    DEPTH=32, R0_ZERO=0
//  Expected read data is pushed to a queue as stimulus is driven and popped when
//  the outputs are sampled. Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) m_if ();
  regfile_multiport_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) s_if ();
  regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) n_if ();

  regfile_multiport #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .R0_ZERO(1'b1)) u_main (
    .clk_i(clk), .rst_i(rst), .rf(m_if.slave));
  regfile_multiport #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NUM_RD(2), .R0_ZERO(1'b1)) u_d16 (
    .clk_i(clk), .rst_i(rst), .rf(s_if.slave));
  regfile_multiport #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .R0_ZERO(1'b0)) u_nz (
    .clk_i(clk), .rst_i(rst), .rf(n_if.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m_if.rd0_we_i = 1'b0; m_if.rd0_i = 5'd0; m_if.rd0_value_i = 32'h0;
    m_if.rd1_we_i = 1'b0; m_if.rd1_i = 5'd0; m_if.rd1_value_i = 32'h0;
    s_if.rd0_we_i = 1'b0; s_if.rd0_i = 4'd0; s_if.rd0_value_i = 32'h0;
    s_if.rd1_we_i = 1'b0; s_if.rd1_i = 4'd0; s_if.rd1_value_i = 32'h0;
    n_if.rd0_we_i = 1'b0; n_if.rd0_i = 5'd0; n_if.rd0_value_i = 32'h0;
    n_if.rd1_we_i = 1'b0; n_if.rd1_i = 5'd0; n_if.rd1_value_i = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    m_if.ra_i = {5'd1, 5'd0};
    s_if.ra_i = {4'd1, 4'd0};
    n_if.ra_i = {5'd1, 5'd0};
    step();
    @(negedge clk);
    checks++;
    if (m_if.busy_o !== 1'b1) begin
      failures++; $display("FAIL reset_busy_main: got %b expected 1", m_if.busy_o);
    end
    checks++;
    if (s_if.busy_o !== 1'b1) begin
      failures++; $display("FAIL reset_busy_d16: got %b expected 1", s_if.busy_o);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL reset_rv0: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (n_if.rv_o[63:32] !== exp_v) begin
      failures++; $display("FAIL reset_rv1_nz: got %h expected %h", n_if.rv_o[63:32], exp_v);
    end
  endtask

  task automatic test_sweep();
    int cnt_m, cnt_s, cnt_n, cyc;
    logic m_b, s_b, n_b;
    logic [4:0] a0, a1;
    logic [3:0] b0, b1;
    step();
    rst = 1'b0;
    cnt_m = 0; cnt_s = 0; cnt_n = 0; cyc = 0;
    do begin
      @(negedge clk);
      m_b = m_if.busy_o; s_b = s_if.busy_o; n_b = n_if.busy_o;
      if (m_b) cnt_m++;
      if (s_b) cnt_s++;
      if (n_b) cnt_n++;
      cyc++;
    end while ((m_b || s_b || n_b) && cyc < 200);
    checks++;
    if (m_b || s_b || n_b) begin
      failures++; $display("FAIL sweep_timeout: busy %b%b%b after %0d cycles expected 000", m_b, s_b, n_b, cyc);
    end
    checks++;
    if (cnt_m != 32) begin
      failures++; $display("FAIL sweep_len_main: got %0d expected 32", cnt_m);
    end
    checks++;
    if (cnt_s != 16) begin
      failures++; $display("FAIL sweep_len_d16: got %0d expected 16", cnt_s);
    end
    checks++;
    if (cnt_n != 32) begin
      failures++; $display("FAIL sweep_len_nz: got %0d expected 32", cnt_n);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a0 = 5'(i); a1 = 5'(31 - i);
      b0 = 4'(i); b1 = 4'(15 - i);
      m_if.ra_i = {a1, a0};
      n_if.ra_i = {a0, a1};
      s_if.ra_i = {b1, b0};
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (m_if.rv_o !== {exp_v, exp_v}) begin
        failures++; $display("FAIL sweep_zero_main addr %0d: got %h expected %h%h", i, m_if.rv_o, exp_v, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (n_if.rv_o !== {exp_v, exp_v}) begin
        failures++; $display("FAIL sweep_zero_nz addr %0d: got %h expected %h%h", i, n_if.rv_o, exp_v, exp_v);
      end
      exp_v = exp_q.pop_front();
      if (i < 16) begin
        checks++;
        if (s_if.rv_o !== {exp_v, exp_v}) begin
          failures++; $display("FAIL sweep_zero_d16 addr %0d: got %h expected %h%h", i, s_if.rv_o, exp_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_basic();
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd5; m_if.rd0_value_i = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    step();
    idle_all();
    m_if.ra_i = {5'd6, 5'd5};
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL basic_read5: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[63:32] !== exp_v) begin
      failures++; $display("FAIL basic_read6: got %h expected %h", m_if.rv_o[63:32], exp_v);
    end
  endtask

  task automatic test_collision();
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd9; m_if.rd0_value_i = 32'h11111111;
    m_if.rd1_we_i = 1'b1; m_if.rd1_i = 5'd9; m_if.rd1_value_i = 32'h22222222;
    exp_q.push_back(32'h22222222);
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd10; m_if.rd0_value_i = 32'hA0A0A0A0;
    m_if.rd1_we_i = 1'b1; m_if.rd1_i = 5'd11; m_if.rd1_value_i = 32'hB1B1B1B1;
    exp_q.push_back(32'hA0A0A0A0);
    exp_q.push_back(32'hB1B1B1B1);
    step();
    idle_all();
    m_if.ra_i = {5'd9, 5'd9};
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o !== {exp_v, exp_v}) begin
      failures++; $display("FAIL collision_rd1_wins: got %h expected %h%h", m_if.rv_o, exp_v, exp_v);
    end
    m_if.ra_i = {5'd11, 5'd10};
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL dual_write_port0: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[63:32] !== exp_v) begin
      failures++; $display("FAIL dual_write_port1: got %h expected %h", m_if.rv_o[63:32], exp_v);
    end
  endtask

  task automatic test_r0();
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd0; m_if.rd0_value_i = 32'hFFFFFFFF;
    n_if.rd0_we_i = 1'b1; n_if.rd0_i = 5'd0; n_if.rd0_value_i = 32'hFFFFFFFF;
    m_if.ra_i = {5'd0, 5'd0};
    n_if.ra_i = {5'd0, 5'd0};
    exp_q.push_back(32'h0);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hFFFFFFFF);
`else
    exp_q.push_back(32'h0);
`endif
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL r0_no_forward: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (n_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL r0_nz_same_cycle: got %h expected %h", n_if.rv_o[31:0], exp_v);
    end
    step();
    idle_all();
    m_if.rd1_we_i = 1'b1; m_if.rd1_i = 5'd0; m_if.rd1_value_i = 32'h12345678;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFFFFFF);
    step();
    idle_all();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o !== {exp_v, exp_v}) begin
      failures++; $display("FAIL r0_dropped: got %h expected %h%h", m_if.rv_o, exp_v, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (n_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL r0_nz_stored: got %h expected %h", n_if.rv_o[31:0], exp_v);
    end
  endtask

  task automatic test_bypass();
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd12; m_if.rd0_value_i = 32'h00001234;
    step();
    m_if.rd0_value_i = 32'hCAFE0001;
    m_if.ra_i = {5'd13, 5'd12};
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hCAFE0001);
`else
    exp_q.push_back(32'h00001234);
`endif
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL bypass_rd0: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd13; m_if.rd0_value_i = 32'hAAAA0000;
    m_if.rd1_we_i = 1'b1; m_if.rd1_i = 5'd13; m_if.rd1_value_i = 32'hBBBB0000;
    exp_q.push_back(32'hCAFE0001);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hBBBB0000);
`else
    exp_q.push_back(32'h0);
`endif
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL bypass_committed12: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[63:32] !== exp_v) begin
      failures++; $display("FAIL bypass_rd1_priority: got %h expected %h", m_if.rv_o[63:32], exp_v);
    end
    step();
    idle_all();
    exp_q.push_back(32'hBBBB0000);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[63:32] !== exp_v) begin
      failures++; $display("FAIL bypass_committed13: got %h expected %h", m_if.rv_o[63:32], exp_v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step();
      m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'(16 + i); m_if.rd0_value_i = 32'h10000000 + 32'(i);
      m_if.rd1_we_i = 1'b1; m_if.rd1_i = 5'(20 + i); m_if.rd1_value_i = 32'h20000000 + 32'(i);
    end
    step();
    idle_all();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_if.ra_i = {5'(20 + i), 5'(16 + i)};
      exp_q.push_back(32'h10000000 + 32'(i));
      exp_q.push_back(32'h20000000 + 32'(i));
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (m_if.rv_o[31:0] !== exp_v) begin
        failures++; $display("FAIL b2b_port0 i=%0d: got %h expected %h", i, m_if.rv_o[31:0], exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (m_if.rv_o[63:32] !== exp_v) begin
        failures++; $display("FAIL b2b_port1 i=%0d: got %h expected %h", i, m_if.rv_o[63:32], exp_v);
      end
    end
  endtask

  task automatic test_midsweep();
    int cnt_m, cyc;
    logic m_b;
    step();
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd3; m_if.rd0_value_i = 32'h00000077;
    step();
    idle_all();
    m_if.ra_i = {5'd3, 5'd3};
    exp_q.push_back(32'h00000077);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL pre_reset_read3: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
    step();
    rst = 1'b1;
    m_if.rd0_we_i = 1'b1; m_if.rd0_i = 5'd3; m_if.rd0_value_i = 32'h00000005;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_if.ra_i = {5'd3, 5'd12};
    exp_q.push_back(32'h0);
    cnt_m = 0; cyc = 0;
    do begin
      @(negedge clk);
      m_b = m_if.busy_o;
      if (cyc == 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (m_if.rv_o[31:0] !== exp_v) begin
          failures++; $display("FAIL clear_masks_read: got %h expected %h", m_if.rv_o[31:0], exp_v);
        end
      end
      if (m_b) cnt_m++;
      cyc++;
    end while (m_b && cyc < 200);
    m_if.rd0_we_i = 1'b0;
    checks++;
    if (m_b) begin
      failures++; $display("FAIL midsweep_timeout: busy %b after %0d cycles expected 0", m_b, cyc);
    end
    checks++;
    if (cnt_m != 32) begin
      failures++; $display("FAIL midsweep_len: got %0d expected 32", cnt_m);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[63:32] !== exp_v) begin
      failures++; $display("FAIL clear_write_ignored3: got %h expected %h", m_if.rv_o[63:32], exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (m_if.rv_o[31:0] !== exp_v) begin
      failures++; $display("FAIL resweep_zero12: got %h expected %h", m_if.rv_o[31:0], exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep();
    test_basic();
    test_collision();
    test_r0();
    test_bypass();
    test_back_to_back();
    test_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
